// File: rtl/arith_exec_unit_pkg.sv
// Shared definitions for the arithmetic execution stage: operation codes
// coming from the operator decoder, FSM state encoding and the result width.
// No ports; imported by the interface, the top level and the divider.
package arith_exec_unit_pkg;

    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_MUL = 8'd3;
    localparam logic [7:0] OP_DIV = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Results are twice the operand width so a full product always fits.
    function automatic int result_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/arith_exec_unit_if.sv
// Request/result bus between the decoder/parser, the execution stage and the
// result formatter.
//   master : upstream side, drives i_ready/op_code/op_a/op_b, sees status.
//   slave  : execution unit, drives busy/result/err/o_ready.
interface arith_exec_unit_if #(
    parameter int WIDTH = 8
);
    import arith_exec_unit_pkg::*;

    logic                             i_ready;
    logic [7:0]                       op_code;
    logic [WIDTH-1:0]                 op_a;
    logic [WIDTH-1:0]                 op_b;
    logic                             busy;
    logic [result_width(WIDTH)-1:0]   result;
    logic                             err;
    logic                             o_ready;

    modport master (
        output i_ready, op_code, op_a, op_b,
        input  busy, result, err, o_ready
    );

    modport slave (
        input  i_ready, op_code, op_a, op_b,
        output busy, result, err, o_ready
    );

endinterface

// File: rtl/arith_exec_unit_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   start               pulse; dividend/divisor sampled and first bit computed
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   done                one-cycle pulse once all WIDTH bits are produced
//   quotient, remainder final values, held until the next start
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] base_rem;
    logic [WIDTH-1:0] base_quo;
    logic [WIDTH-1:0] base_dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // The start cycle already performs the first step from fresh operands, so
    // the last bit lands exactly WIDTH cycles after start.
    always_comb begin
        base_rem = start ? '0 : rem_q;
        base_quo = start ? dividend : quo_q;
        base_dvs = start ? divisor : dvs_q;
        shifted  = {base_rem, base_quo[WIDTH-1]};
        trial    = shifted - {1'b0, base_dvs};
        // trial[WIDTH] set means the subtraction went negative: restore.
        step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {base_quo[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = divisor;
            cnt_d = CW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/arith_exec_unit.sv
// Arithmetic execution stage: add/sub/mul in one EXEC cycle, div through the
// sequential divider. Result/err are registered and qualified by a one-cycle
// o_ready pulse toward the result formatter.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    arith_exec_unit_if.slave (i_ready/op_code/op_a/op_b in,
//          busy/result/err/o_ready out)
// Build option: ARITH_EXEC_SIGNED_EN selects two's complement operands, a
// signed product and signed division with an extra sign fix-up cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_ready; operands latched on acceptance
// EXEC    | single-cycle ops staged; div with non-zero divisor starts
// DIV     | divider iterating (plus one fix-up cycle in signed builds)
// DONE    | staged result copied to outputs, o_ready pulsed next cycle
module arith_exec_unit
    import arith_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    arith_exec_unit_if.slave bus
);

    localparam int RW = result_width(WIDTH);

    state_e           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [RW-1:0]    stage_res_q, stage_res_d;
    logic             stage_err_q, stage_err_d;
    logic [RW-1:0]    result_q, result_d;
    logic             err_q, err_d;
    logic             o_ready_q, o_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   diff_w;
    logic [RW-1:0]    add_res;
    logic [RW-1:0]    sub_res;
    logic [RW-1:0]    mul_res;

    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

`ifdef ARITH_EXEC_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 fix_q, fix_d;
    logic [WIDTH:0]       sum_w;
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] prod_w;
    logic [WIDTH-1:0]     fix_quo;
    logic [WIDTH-1:0]     fix_rem;
    logic                 div_ovf;

    assign sum_w   = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    assign diff_w  = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    assign a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_w  = a_ext * b_ext;
    assign add_res = {{(RW-WIDTH-1){sum_w[WIDTH]}}, sum_w};
    assign mul_res = prod_w;

    // Divide magnitudes; the most negative value maps onto 2^(WIDTH-1), which
    // still fits the unsigned divider.
    assign div_a   = a_q[WIDTH-1] ? -a_q : a_q;
    assign div_b   = b_q[WIDTH-1] ? -b_q : b_q;
    // Quotient truncates toward zero, remainder follows the dividend's sign.
    assign fix_quo = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo : div_quo;
    assign fix_rem = a_q[WIDTH-1] ? -div_rem : div_rem;
    // MOST_NEG / -1 wraps back to MOST_NEG; flag it rather than saturate.
    assign div_ovf = (a_q == MOST_NEG) && (b_q == '1);
`else
    logic [WIDTH:0] sum_w;

    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w  = {1'b0, a_q} - {1'b0, b_q};
    assign add_res = {{(RW-WIDTH-1){1'b0}}, sum_w};
    assign mul_res = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign div_a   = a_q;
    assign div_b   = b_q;
`endif

    // Both builds keep the (WIDTH+1)-bit difference and sign-extend it.
    assign sub_res = {{(RW-WIDTH-1){diff_w[WIDTH]}}, diff_w};

    assign div_start = (state_q == ST_EXEC) && (op_q == OP_DIV) && (b_q != '0);

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_seq_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_a),
        .divisor   (div_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        stage_res_d = stage_res_q;
        stage_err_d = stage_err_q;
        result_d    = result_q;
        err_d       = err_q;
        o_ready_d   = 1'b0;
`ifdef ARITH_EXEC_SIGNED_EN
        fix_d       = fix_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_ready) begin
                    op_d    = bus.op_code;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    err_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                stage_err_d = 1'b0;
                state_d     = ST_DONE;
                case (op_q)
                    OP_ADD: stage_res_d = add_res;
                    OP_SUB: stage_res_d = sub_res;
                    OP_MUL: stage_res_d = mul_res;
                    OP_DIV: begin
                        if (b_q == '0) begin
                            stage_res_d = '1;
                            stage_err_d = 1'b1;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                    default: begin
                        stage_res_d = '0;
                        stage_err_d = 1'b1;
                    end
                endcase
            end
            ST_DIV: begin
`ifdef ARITH_EXEC_SIGNED_EN
                if (fix_q) begin
                    fix_d       = 1'b0;
                    stage_res_d = {{(RW-2*WIDTH){1'b0}}, fix_rem, fix_quo};
                    stage_err_d = div_ovf;
                    state_d     = ST_DONE;
                end else if (div_done) begin
                    fix_d = 1'b1;
                end
`else
                if (div_done) begin
                    stage_res_d = {{(RW-2*WIDTH){1'b0}}, div_rem, div_quo};
                    stage_err_d = 1'b0;
                    state_d     = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                result_d  = stage_res_q;
                err_d     = stage_err_q;
                o_ready_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            stage_res_q <= '0;
            stage_err_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            o_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ARITH_EXEC_SIGNED_EN
            fix_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            stage_res_q <= stage_res_d;
            stage_err_q <= stage_err_d;
            result_q    <= result_d;
            err_q       <= err_d;
            o_ready_q   <= o_ready_d;
            busy_q      <= busy_d;
`ifdef ARITH_EXEC_SIGNED_EN
            fix_q       <= fix_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.result  = result_q;
    assign bus.err     = err_q;
    assign bus.o_ready = o_ready_q;

endmodule

// File: doc/arith_exec_unit.md
Name: arith_exec_unit

Overview:
- Execution stage directly downstream of the operator decoder.
- Consumes the decoded op_code (1 = add, 2 = sub, 3 = mul, 4 = div) plus two operands latched by the input parser.
- Produces a registered 2*WIDTH result with a one-cycle o_ready pulse, which feeds the result formatter / UART transmit path.
- Add, sub and mul are single-cycle; div is an iterative restoring divider.

Parameters:
- WIDTH, 8, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- i_ready  input  1  request strobe; op_code/op_a/op_b valid this cycle.
- op_code  input  8  decoded operation code from the decoder.
- op_a  input  WIDTH  left operand.
- op_b  input  WIDTH  right operand.
- busy  output  1  high whenever the FSM is not in IDLE.
- result  output  2*WIDTH  registered result.
- err  output  1  error flag, valid with o_ready.
- o_ready  output  1  one-cycle pulse: result/err valid.

Behaviour:
- Reset (reset==0 at a clk edge): FSM to IDLE; result=0, err=0, o_ready=0, busy=0.
- Reset has priority over all other events, including mid-division (the operation is abandoned and no o_ready is issued).
- FSM states: IDLE, EXEC, DIV, DONE.
- IDLE:
  - If i_ready=1, latch op_code/op_a/op_b and go to EXEC.
  - Otherwise stay.
- EXEC:
  - op 1: result = zero-extended op_a + op_b (carry lands in bit WIDTH).
  - op 2: result = (WIDTH+1)-bit difference op_a - op_b, sign-extended to 2*WIDTH.
  - op 3: result = full product op_a * op_b.
  - op 4 with op_b==0: result = all ones, err=1.
  - op 4 with op_b!=0: initialise divider, go to DIV.
  - Any other code (0, >=5): result=0, err=1.
  - Non-div paths go to DONE.
- DIV:
  - One quotient bit per cycle, exactly WIDTH cycles, then DONE.
  - Final result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, err=0.
- DONE: o_ready=1 for exactly this cycle, then IDLE.
- result and err hold their values until the next DONE or reset. err is cleared on every new acceptance.
- Latency, counting the accept edge as edge 0:
  - Non-div ops and divide-by-zero: o_ready high in the cycle after edge 2.
  - Div: o_ready high in the cycle after edge WIDTH+2.
- busy is high from the cycle after the accept edge through the DONE cycle.
- i_ready asserted while busy=1 is ignored. No queueing; the upstream stage must wait for busy=0.
- i_ready asserted in the cycle immediately following DONE (state is IDLE) is accepted, giving back-to-back throughput.

Optional Feature:
- Macro: ARITH_EXEC_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - add/sub results are sign-extended.
  - mul is a signed product.
  - div uses magnitude division with sign fix-up: quotient truncates toward zero, remainder takes the sign of op_a.
  - Adds one extra cycle in DIV for the fix-up, so div latency becomes WIDTH+3.
  - Special case: most-negative / -1 returns quotient = most-negative with err=1.
- Undefined: all operations are unsigned exactly as specified above, with no fix-up cycle.

Decomposition:
- Shared package holds:
  - Op code constants: OP_ADD=8'd1, OP_SUB=8'd2, OP_MUL=8'd3, OP_DIV=8'd4.
  - FSM state encoding.
  - The result-width expression.
- Sub-module seq_divider (start/done handshake, WIDTH-cycle restoring divider, outputs quotient and remainder) is the natural split. The top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan:
- Add, WIDTH=8: op_a=200, op_b=100 -> result=16'h012C, err=0, o_ready a single pulse 2 cycles after the accept edge, busy low afterwards.
- Sub: 5-7 -> result=16'hFFFE. Mul: 255*255 -> result=16'hFE01. Run back-to-back by asserting i_ready the cycle after each o_ready; both must be accepted.
- Div: 100/7 -> result=16'h020E (q=14, r=2), o_ready 10 cycles after accept, busy high throughout; an i_ready pulse mid-operation is ignored.
- Divide-by-zero: 9/0 -> result=16'hFFFF, err=1, 2-cycle latency. Unknown op_code 8'h07 -> result=0, err=1.
- Reset: drive reset low at cycle 4 of a division -> next cycle busy=0, result=0, err=0, and no o_ready follows. A fresh add after reset completes normally.
- With ARITH_EXEC_SIGNED_EN: -7/2 (8'hF9/8'h02) -> result=16'hFFFD (q=-3, r=-1), latency 11 cycles. Also check -128/-1 -> err=1.
